mac_operand_sequencer: RTL and testbench
========================================

# mac_operand_sequencer

Upstream feeder for the `MAC` accumulator. It buffers A and B operand streams in two internal first-word-fall-through FIFOs. On `start` it runs one dot-product job: it clears the MAC, streams `len` operand pairs into it, waits for the final accumulation to land, then captures `Cout` as a registered result. It owns every MAC control input (`En`, `Clr`, `Ain`, `Bin`), so software and higher-level blocks only push data and issue jobs.

## Interface
- `DATA_WIDTH`, 8, operand width; must match the MAC instance.
- `DEPTH`, 8, entries per operand FIFO; power of two, ≥2.
- `clk`  input  1  single clock domain, rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `a_wr_en`  input  1  push `a_wr_data` into the A FIFO.
- `a_wr_data`  input  DATA_WIDTH  A operand.
- `b_wr_en`  input  1  push `b_wr_data` into the B FIFO.
- `b_wr_data`  input  DATA_WIDTH  B operand.
- `a_full`, `b_full`  output  1  FIFO count == DEPTH.
- `a_count`, `b_count`  output  $clog2(DEPTH+1)  current occupancy.
- `start`  input  1  job request; sampled only in IDLE.
- `len`  input  $clog2(DEPTH+1)  pairs to consume; sampled with `start`.
- `busy`  output  1  high in CLEAR, STREAM, DRAIN and DONE.
- `start_err`  output  1  one-cycle pulse when a start is rejected.
- `mac_en`  output  1  drives MAC `En`.
- `mac_clr`  output  1  drives MAC `Clr`.
- `mac_a`, `mac_b`  output  DATA_WIDTH  drive MAC `Ain`/`Bin`.
- `mac_cout`  input  3*DATA_WIDTH  MAC `Cout`.
- `result`  output  3*DATA_WIDTH  captured dot product; holds until the next capture.
- `result_valid`  output  1  one-cycle pulse when `result` updates.

## Operation
- **MAC contract.** On a clock edge with `Clr`=1, the accumulator is zeroed (Clr has priority). Otherwise, with `En`=1, the accumulator adds `Ain*Bin`. `Cout` reflects the accumulator after the edge.
- **FIFOs.**
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - The head entry is visible combinationally.
  - A push is accepted if count<DEPTH, or if a pop occurs in the same cycle; otherwise it is silently dropped.
  - A push to an empty FIFO is visible at the head on the next cycle.
- **State machine: IDLE → CLEAR → STREAM → DRAIN → DONE → IDLE.**
  - IDLE:
    - `start`=1 with 1≤`len`≤`a_count` and `len`≤`b_count` latches `len` into a down-counter and moves to CLEAR.
    - Any other `start` pulses `start_err` for one cycle and stays in IDLE.
  - CLEAR: `mac_clr`=1, `mac_en`=0, for one cycle.
  - STREAM:
    - `mac_en`=1; `mac_a`/`mac_b` = FIFO heads; both FIFOs pop every cycle.
    - The counter decrements each cycle; the state exits to DRAIN after `len` cycles.
  - DRAIN: `mac_en`=0 for one cycle, so the last product lands in `mac_cout`. `result` ← `mac_cout` at the end of this cycle.
  - DONE: `result_valid`=1 for one cycle, then IDLE.
- **Output values outside STREAM.** `mac_a`/`mac_b` are 0 outside STREAM. `mac_en`/`mac_clr` are combinational decodes of state, glitch-free relative to `clk`.
- **Pushes during a job.** Pushes remain legal throughout a job; `len` was checked at start, so FIFO underflow is impossible.
- **Width.** No truncation occurs within the MAC's 3*DATA_WIDTH range; `result` is copied verbatim.

## Timing
- **Reset values.** While `rst_n`=0:
  - State is IDLE and both FIFOs are empty.
  - `a_count`=`b_count`=0, `a_full`=`b_full`=0.
  - `busy`=`start_err`=`mac_en`=`mac_clr`=0.
  - `mac_a`=`mac_b`=0, `result`=0, `result_valid`=0.
- **Job timeline.** `start` is accepted at the edge ending cycle 0.
  - Cycle 1: CLEAR.
  - Cycles 2..len+1: STREAM.
  - Cycle len+2: DRAIN.
  - Cycle len+3: DONE, with `result_valid`=1.
  - Cycle len+4: back in IDLE, `busy`=0; the next `start` may be accepted here.
- **Total latency.** `start` to `result_valid` is len+3 cycles.
- **Counts.** `a_count`/`b_count` update on the edge after each push or pop.
- **Reset mid-job.** An asynchronous assertion of `rst_n` in any state immediately returns all outputs to reset values, discards FIFO contents, and emits no `result_valid`.

## Test plan
- **Reset.** Assert `rst_n`=0 with pushes active → all outputs 0 and both counts 0; after release, counts stay 0 until a push.
- **Basic job.** Push A={3,4,1}, B={2,3,5}, then `start` with `len`=3.
  - CLEAR lasts one cycle.
  - `mac_en` is high for 3 cycles carrying pairs (3,2),(4,3),(1,5).
  - `result`=23 with `result_valid` in cycle 6; counts return to 0.
- **Back-to-back jobs.** After the basic job, push A={2,3}, B={6,7} and `start` with `len`=2 → `result`=33, not 56, proving the clear occurs between jobs.
- **Rejected starts.**
  - `start` with `len`=0 → `start_err` pulse, no `mac_en`, `busy`=0.
  - `start` with `len`=4 when `a_count`=3 → same response.
- **Full FIFOs.** Push 9 values of 255 into each FIFO (DEPTH=8).
  - `a_full`=1 and the 9th push is dropped; `a_count`=8.
  - A job with `len`=8 → `result`=520200; pointers wrap correctly on a refill.
- **Reset mid-STREAM.** Assert `rst_n` during the 2nd STREAM cycle → `mac_en` drops immediately, there is no `result_valid`, and counts are 0 after release.

Source files
------------

// File: rtl/mac_operand_sequencer.sv
// Operand feeder for a MAC accumulator: two FWFT operand FIFOs plus a job FSM that
// clears the MAC, streams len operand pairs, waits for the last product and captures Cout.

module mac_operand_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [W-1:0]               data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [PW-1:0] PONE_C  = PW'(1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok_s;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok_s = push_i && ((count_q != DEPTH_C) || pop_i);
    assign head_o    = mem_q[rptr_q];
    assign count_o   = count_q;
    assign full_o    = (count_q == DEPTH_C);

    // Storage array; contents need no reset because pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok_s) begin
                wptr_q <= wptr_q + PONE_C;
            end
            if (pop_i) begin
                rptr_q <= rptr_q + PONE_C;
            end
            case ({push_ok_s, pop_i})
                2'b10:   count_q <= count_q + ONE_C;
                2'b01:   count_q <= count_q - ONE_C;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

module mac_operand_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        a_wr_en_i,
    input  logic [DATA_WIDTH-1:0]       a_wr_data_i,
    input  logic                        b_wr_en_i,
    input  logic [DATA_WIDTH-1:0]       b_wr_data_i,
    output logic                        a_full_o,
    output logic                        b_full_o,
    output logic [$clog2(DEPTH+1)-1:0]  a_count_o,
    output logic [$clog2(DEPTH+1)-1:0]  b_count_o,
    input  logic                        start_i,
    input  logic [$clog2(DEPTH+1)-1:0]  len_i,
    output logic                        busy_o,
    output logic                        start_err_o,
    output logic                        mac_en_o,
    output logic                        mac_clr_o,
    output logic [DATA_WIDTH-1:0]       mac_a_o,
    output logic [DATA_WIDTH-1:0]       mac_b_o,
    input  logic [3*DATA_WIDTH-1:0]     mac_cout_i,
    output logic [3*DATA_WIDTH-1:0]     result_o,
    output logic                        result_valid_o
);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    state_e                  state_q;
    logic [CW-1:0]           cnt_q;
    logic [3*DATA_WIDTH-1:0] result_q;
    logic                    start_err_q;
    logic                    pop_s;
    logic                    start_ok_s;
    logic [DATA_WIDTH-1:0]   a_head_s;
    logic [DATA_WIDTH-1:0]   b_head_s;

    assign pop_s = (state_q == S_STREAM);

    mac_operand_fifo #(.W(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (a_wr_en_i),
        .data_i  (a_wr_data_i),
        .pop_i   (pop_s),
        .head_o  (a_head_s),
        .count_o (a_count_o),
        .full_o  (a_full_o)
    );

    mac_operand_fifo #(.W(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (b_wr_en_i),
        .data_i  (b_wr_data_i),
        .pop_i   (pop_s),
        .head_o  (b_head_s),
        .count_o (b_count_o),
        .full_o  (b_full_o)
    );

    // Both FIFOs must already hold len entries, so streaming can never underflow.
    assign start_ok_s = (len_i != '0) && (len_i <= a_count_o) && (len_i <= b_count_o);

    // Job sequencing, down-counter, rejection pulse and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            result_q    <= '0;
            start_err_q <= 1'b0;
        end else begin
            start_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i && start_ok_s) begin
                        cnt_q   <= len_i;
                        state_q <= S_CLEAR;
                    end else if (start_i) begin
                        start_err_q <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_CLEAR: state_q <= S_STREAM;
                S_STREAM: begin
                    cnt_q <= cnt_q - ONE_C;
                    if (cnt_q == ONE_C) begin
                        state_q <= S_DRAIN;
                    end else begin
                        state_q <= S_STREAM;
                    end
                end
                S_DRAIN: begin
                    result_q <= mac_cout_i;
                    state_q  <= S_DONE;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Output decode from the registered state only, so MAC controls cannot glitch.
    always_comb begin
        busy_o         = 1'b1;
        mac_en_o       = 1'b0;
        mac_clr_o      = 1'b0;
        mac_a_o        = '0;
        mac_b_o        = '0;
        result_valid_o = 1'b0;
        case (state_q)
            S_IDLE:  busy_o = 1'b0;
            S_CLEAR: mac_clr_o = 1'b1;
            S_STREAM: begin
                mac_en_o = 1'b1;
                mac_a_o  = a_head_s;
                mac_b_o  = b_head_s;
            end
            S_DRAIN: mac_en_o = 1'b0;
            S_DONE:  result_valid_o = 1'b1;
            default: busy_o = 1'b0;
        endcase
    end

    assign start_err_o = start_err_q;
    assign result_o    = result_q;
endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Scoreboard bench for mac_operand_sequencer driving a behavioural MAC.

module tb_mac_operand_sequencer;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = 4;
    localparam int RW    = 24;

    typedef struct {logic [DW-1:0] a; logic [DW-1:0] b; int cyc;} pair_t;
    typedef struct {logic [RW-1:0] v; int cyc;} res_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_wr_en = 1'b0, b_wr_en = 1'b0;
    logic [DW-1:0] a_wr_data = '0, b_wr_data = '0;
    logic          a_full, b_full;
    logic [CW-1:0] a_count, b_count;
    logic          start = 1'b0;
    logic [CW-1:0] len = '0;
    logic          busy, start_err, mac_en, mac_clr, result_valid;
    logic [DW-1:0] mac_a, mac_b;
    logic [RW-1:0] mac_cout, result;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    pair_t       exp_pair[$];
    res_t        exp_res[$];
    int          exp_err[$];
    logic [DW-1:0] m_a[$];
    logic [DW-1:0] m_b[$];

    mac_operand_sequencer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .a_wr_en_i      (a_wr_en),
        .a_wr_data_i    (a_wr_data),
        .b_wr_en_i      (b_wr_en),
        .b_wr_data_i    (b_wr_data),
        .a_full_o       (a_full),
        .b_full_o       (b_full),
        .a_count_o      (a_count),
        .b_count_o      (b_count),
        .start_i        (start),
        .len_i          (len),
        .busy_o         (busy),
        .start_err_o    (start_err),
        .mac_en_o       (mac_en),
        .mac_clr_o      (mac_clr),
        .mac_a_o        (mac_a),
        .mac_b_o        (mac_b),
        .mac_cout_i     (mac_cout),
        .result_o       (result),
        .result_valid_o (result_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural MAC: Clr has priority over En.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       mac_cout <= '0;
        else if (mac_clr) mac_cout <= '0;
        else if (mac_en)  mac_cout <= mac_cout + RW'(mac_a) * RW'(mac_b);
    end

    function automatic void chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Monitor: every presented output event must match the head of its queue.
    always @(negedge clk) begin
        pair_t p;
        res_t  r;
        int    e;
        if (rst_n) begin
            if (mac_en) begin
                if (exp_pair.size() == 0) chk("unexpected_mac_en", 1, 0);
                else begin
                    p = exp_pair.pop_front();
                    chk("pair_a", mac_a, p.a);
                    chk("pair_b", mac_b, p.b);
                    chk("pair_cycle", cyc, p.cyc);
                end
            end
            if (result_valid) begin
                if (exp_res.size() == 0) chk("unexpected_result_valid", 1, 0);
                else begin
                    r = exp_res.pop_front();
                    chk("result_value", result, r.v);
                    chk("result_cycle", cyc, r.cyc);
                end
            end
            if (start_err) begin
                if (exp_err.size() == 0) chk("unexpected_start_err", 1, 0);
                else begin
                    e = exp_err.pop_front();
                    chk("start_err_cycle", cyc, e);
                end
            end
        end
    end

    task automatic push_ab(input logic [DW-1:0] a, input logic [DW-1:0] b);
        a_wr_en = 1'b1; a_wr_data = a;
        b_wr_en = 1'b1; b_wr_data = b;
        if (m_a.size() < DEPTH) m_a.push_back(a);
        if (m_b.size() < DEPTH) m_b.push_back(b);
        @(negedge clk);
        a_wr_en = 1'b0; b_wr_en = 1'b0;
    endtask

    task automatic issue(input logic [CW-1:0] l, input bit ok, input logic [RW-1:0] v);
        pair_t p;
        res_t  r;
        start = 1'b1; len = l;
        if (ok) begin
            for (int i = 0; i < int'(l); i++) begin
                p.a = m_a.pop_front();
                p.b = m_b.pop_front();
                p.cyc = cyc + 2 + i;
                exp_pair.push_back(p);
            end
            r.v = v; r.cyc = cyc + int'(l) + 3;
            exp_res.push_back(r);
        end else begin
            exp_err.push_back(cyc + 1);
        end
        @(negedge clk);
        start = 1'b0; len = '0;
    endtask

    task automatic run_job(input logic [CW-1:0] l, input logic [RW-1:0] v);
        issue(l, 1'b1, v);
        chk("clear_mac_clr", mac_clr, 1);
        chk("clear_mac_en", mac_en, 0);
        chk("clear_busy", busy, 1);
        repeat (int'(l) + 3) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("result_hold", result, v);
    endtask

    task automatic reject(input logic [CW-1:0] l);
        issue(l, 1'b0, '0);
        chk("reject_busy", busy, 0);
        chk("reject_mac_clr", mac_clr, 0);
        @(negedge clk);
    endtask

    initial begin
        // Reset with pushes active
        a_wr_en = 1'b1; b_wr_en = 1'b1; a_wr_data = 8'd9; b_wr_data = 8'd9;
        repeat (3) @(negedge clk);
        chk("rst_a_count", a_count, 0);
        chk("rst_b_count", b_count, 0);
        chk("rst_full", {a_full, b_full}, 0);
        chk("rst_ctrl", {busy, start_err, mac_en, mac_clr, result_valid}, 0);
        chk("rst_mac_ab", {mac_a, mac_b}, 0);
        chk("rst_result", result, 0);
        a_wr_en = 1'b0; b_wr_en = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_count", {a_count, b_count}, 0);

        // Basic job: 3*2 + 4*3 + 1*5 = 23
        push_ab(8'd3, 8'd2); push_ab(8'd4, 8'd3); push_ab(8'd1, 8'd5);
        chk("basic_a_count", a_count, 3);
        chk("basic_b_count", b_count, 3);
        run_job(4'd3, 24'd23);
        chk("basic_counts_empty", {a_count, b_count}, 0);

        // Back-to-back: 2*6 + 3*7 = 33 (56 if the clear were missing)
        push_ab(8'd2, 8'd6); push_ab(8'd3, 8'd7);
        run_job(4'd2, 24'd33);

        // Rejected starts
        reject(4'd0);
        chk("reject_result_held", result, 33);
        push_ab(8'd1, 8'd2); push_ab(8'd1, 8'd2); push_ab(8'd1, 8'd2);
        reject(4'd4);
        chk("reject_counts_kept", a_count, 3);
        run_job(4'd3, 24'd6);

        // Full FIFOs: ninth push dropped; 8 * 255 * 255 = 520200
        for (int i = 0; i < 9; i++) push_ab(8'd255, 8'd255);
        chk("full_a", a_full, 1);
        chk("full_b", b_full, 1);
        chk("full_a_count", a_count, 8);
        chk("full_b_count", b_count, 8);
        run_job(4'd8, 24'd520200);
        chk("drained_full", {a_full, b_full}, 0);

        // Refill after wrap: 1*4 + 2*5 + 3*6 = 32
        push_ab(8'd1, 8'd4); push_ab(8'd2, 8'd5); push_ab(8'd3, 8'd6);
        run_job(4'd3, 24'd32);

        // Reset during the second STREAM cycle
        push_ab(8'd5, 8'd1); push_ab(8'd6, 8'd1); push_ab(8'd7, 8'd1);
        issue(4'd3, 1'b1, 24'd18);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_pair.delete(); exp_res.delete(); m_a.delete(); m_b.delete();
        #1;
        chk("midrst_mac_en", mac_en, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_result", result, 0);
        chk("midrst_count", {a_count, b_count}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("midrst_post_count", {a_count, b_count}, 0);
        chk("midrst_post_busy", busy, 0);

        chk("leftover_pairs", exp_pair.size(), 0);
        chk("leftover_results", exp_res.size(), 0);
        chk("leftover_errs", exp_err.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
